// File: rtl/sldu_p2_slide_seq_pkg.sv
// ----------------------------------------------------------------------------
// sldu_p2_slide_seq_pkg
// Shared types and helpers for the SLDU power-of-two slide sequencer.
//   - idx_width()     : index width helper (minimum 1 bit)
//   - slide_dir_e     : slide direction (SLIDE_UP / SLIDE_DOWN)
//   - sldu_p2_pass_t  : one pass command {stride, dir, last}
// Optional feature macro used by the sequencer: SLDU_P2_SEQ_PERF_EN
// ----------------------------------------------------------------------------
package sldu_p2_slide_seq_pkg;

   localparam int unsigned NR_LANES_DFLT = 32'd4;
   localparam int unsigned ID_WIDTH_DFLT = 32'd3;

   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction

   // Bytes of one lane-spanning window need this many stride bits.
   localparam int unsigned SEQ_STRIDE_W = idx_width(32'd8 * NR_LANES_DFLT);

   typedef enum logic {
      SLIDE_UP   = 1'b0,
      SLIDE_DOWN = 1'b1
   } slide_dir_e;

   typedef struct packed {
      logic [SEQ_STRIDE_W-1:0] stride;
      slide_dir_e              dir;
      logic                    last;
   } sldu_p2_pass_t;

endpackage

// File: rtl/sldu_p2_slide_seq_if.sv
// ----------------------------------------------------------------------------
// sldu_p2_slide_seq_if
// Request, pass-command and response channels of the slide sequencer.
//   slave  : sequencer view (receives requests, issues passes and responses)
//   master : environment view (requester + datapath + response consumer)
// ----------------------------------------------------------------------------
interface sldu_p2_slide_seq_if #(
   parameter int unsigned StrideW = 32'd5,
   parameter int unsigned IdWidth = 32'd3,
   parameter int unsigned NpW     = 32'd4
) ();
   logic               req_valid_i;
   logic               req_ready_o;
   logic [StrideW-1:0] req_stride_i;
   logic               req_dir_i;
   logic [IdWidth-1:0] req_id_i;
   logic               pass_valid_o;
   logic               pass_ready_i;
   logic [StrideW-1:0] pass_stride_o;
   logic               pass_dir_o;
   logic               pass_last_o;
   logic               pass_done_i;
   logic               rsp_valid_o;
   logic               rsp_ready_i;
   logic [IdWidth-1:0] rsp_id_o;
   logic [NpW-1:0]     rsp_npasses_o;

   modport slave (
      input  req_valid_i, req_stride_i, req_dir_i, req_id_i,
      input  pass_ready_i, pass_done_i, rsp_ready_i,
      output req_ready_o, pass_valid_o, pass_stride_o, pass_dir_o, pass_last_o,
      output rsp_valid_o, rsp_id_o, rsp_npasses_o
   );

   modport master (
      output req_valid_i, req_stride_i, req_dir_i, req_id_i,
      output pass_ready_i, pass_done_i, rsp_ready_i,
      input  req_ready_o, pass_valid_o, pass_stride_o, pass_dir_o, pass_last_o,
      input  rsp_valid_o, rsp_id_o, rsp_npasses_o
   );
endinterface

// File: rtl/sldu_p2_slide_seq_pass_pick.sv
// ----------------------------------------------------------------------------
// sldu_p2_pass_pick (combinational)
// For a remaining-stride vector: one-hot of the lowest set bit, a flag that
// exactly one bit is set, and the population count.
//   vec_i    : remaining stride
//   lsb_o    : lowest set bit, one-hot (zero when vec_i is zero)
//   single_o : vec_i has exactly one set bit
//   cnt_o    : number of set bits
// ----------------------------------------------------------------------------
module sldu_p2_pass_pick #(
   parameter int unsigned W    = 32'd5,
   parameter int unsigned CntW = 32'd4
) (
   input  logic [W-1:0]    vec_i,
   output logic [W-1:0]    lsb_o,
   output logic            single_o,
   output logic [CntW-1:0] cnt_o
);

   // x & -x isolates the lowest set bit; x & (x-1) clears it.
   always_comb begin
      lsb_o    = vec_i & (~vec_i + W'(1'b1));
      single_o = (vec_i != {W{1'b0}}) && ((vec_i & (vec_i - W'(1'b1))) == {W{1'b0}});
      cnt_o    = {CntW{1'b0}};
      for (int unsigned i = 0; i < W; i++) begin
         cnt_o = cnt_o + CntW'(vec_i[i]);
      end
   end

endmodule

// File: rtl/sldu_p2_slide_seq.sv
// ----------------------------------------------------------------------------
// sldu_p2_slide_seq
// Splits a slide request with an arbitrary byte stride into power-of-two
// passes, lowest set bit first, one pass in flight at a time, then returns
// one response carrying the request tag and the number of passes.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : abort the current request, no response
//   bus (slave)   : request / pass command / response channels
//   busy_o        : sequencer not idle
// Optional (macro SLDU_P2_SEQ_PERF_EN): perf_passes_o, perf_reqs_o,
//   perf_stall_o wrapping 32-bit event counters.
// All outputs are driven straight from flops.
// ----------------------------------------------------------------------------
module sldu_p2_slide_seq
   import sldu_p2_slide_seq_pkg::*;
#(
   parameter int unsigned NrLanes = NR_LANES_DFLT,
   parameter int unsigned IdWidth = ID_WIDTH_DFLT
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   sldu_p2_slide_seq_if.slave bus,
   output logic               busy_o
`ifdef SLDU_P2_SEQ_PERF_EN
   ,
   output logic [31:0]        perf_passes_o,
   output logic [31:0]        perf_reqs_o,
   output logic [31:0]        perf_stall_o
`endif
);

   localparam int unsigned StrideW = idx_width(32'd8 * NrLanes);
   localparam int unsigned NpW     = idx_width(StrideW) + 32'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } p2_seq_state_e;

   p2_seq_state_e  state_q, state_d;
   logic [StrideW-1:0] rem_q, rem_d, rem_clr_s;
   logic [IdWidth-1:0] id_q, id_d;
   slide_dir_e     dir_q, dir_d;
   logic [NpW-1:0] npasses_q, npasses_d;
   sldu_p2_pass_t  pass_q, pass_d;
   logic           pass_valid_q, pass_valid_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           req_ready_q, req_ready_d;
   logic           busy_q, busy_d;
   logic           accept_s;
   logic [StrideW-1:0] lsb_s;
   logic           single_s;
   logic [NpW-1:0] pop_s;

   // Pick logic looks at the next remaining stride so pass outputs can be registered.
   sldu_p2_pass_pick #(.W(StrideW), .CntW(NpW)) i_pick (
      .vec_i    (rem_d),
      .lsb_o    (lsb_s),
      .single_o (single_s),
      .cnt_o    (pop_s)
   );

   assign accept_s  = (state_q == IDLE) && bus.req_valid_i && !flush_i;
   assign rem_clr_s = rem_q & (rem_q - StrideW'(1'b1));

   // Next-state and working-register update; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      id_d    = id_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               rem_d   = bus.req_stride_i;
               id_d    = bus.req_id_i;
               dir_d   = slide_dir_e'(bus.req_dir_i);
               state_d = (bus.req_stride_i != {StrideW{1'b0}}) ? ISSUE : RESP;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (bus.pass_ready_i) begin
               state_d = WAIT;
            end else begin
               state_d = ISSUE;
            end
         end
         WAIT: begin
            if (bus.pass_done_i) begin
               rem_d   = rem_clr_s;
               state_d = (rem_clr_s == {StrideW{1'b0}}) ? RESP : ISSUE;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
            rem_d   = {StrideW{1'b0}};
         end
      endcase
      if (flush_i) begin
         state_d = IDLE;
         rem_d   = {StrideW{1'b0}};
      end else begin
         state_d = state_d;
      end
   end

   // Registered output values derived from the next state.
   always_comb begin
      npasses_d    = accept_s ? pop_s : npasses_q;
      pass_valid_d = (state_d == ISSUE);
      rsp_valid_d  = (state_d == RESP);
      req_ready_d  = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      pass_d.dir   = dir_d;
      if (state_d == ISSUE) begin
         pass_d.stride = lsb_s;
         pass_d.last   = single_s;
      end else begin
         pass_d.stride = {StrideW{1'b0}};
         pass_d.last   = 1'b0;
      end
   end

   // FSM state and all output flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         rem_q        <= {StrideW{1'b0}};
         id_q         <= {IdWidth{1'b0}};
         dir_q        <= SLIDE_UP;
         npasses_q    <= {NpW{1'b0}};
         pass_q       <= '{stride: {StrideW{1'b0}}, dir: SLIDE_UP, last: 1'b0};
         pass_valid_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         id_q         <= id_d;
         dir_q        <= dir_d;
         npasses_q    <= npasses_d;
         pass_q       <= pass_d;
         pass_valid_q <= pass_valid_d;
         rsp_valid_q  <= rsp_valid_d;
         req_ready_q  <= req_ready_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.req_ready_o   = req_ready_q;
   assign bus.pass_valid_o  = pass_valid_q;
   assign bus.pass_stride_o = pass_q.stride;
   assign bus.pass_dir_o    = pass_q.dir;
   assign bus.pass_last_o   = pass_q.last;
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_id_o      = id_q;
   assign bus.rsp_npasses_o = npasses_q;
   assign busy_o            = busy_q;

`ifdef SLDU_P2_SEQ_PERF_EN
   logic [31:0] perf_passes_q, perf_passes_d;
   logic [31:0] perf_reqs_q, perf_reqs_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Event counters wrap naturally at 2^32.
   always_comb begin
      perf_passes_d = perf_passes_q + ((pass_valid_q && bus.pass_ready_i) ? 32'd1 : 32'd0);
      perf_reqs_d   = perf_reqs_q + ((rsp_valid_q && bus.rsp_ready_i) ? 32'd1 : 32'd0);
      perf_stall_d  = perf_stall_q + ((state_q == ISSUE && !bus.pass_ready_i) ? 32'd1 : 32'd0);
   end

   // Performance counter flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_passes_q <= 32'd0;
         perf_reqs_q   <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else begin
         perf_passes_q <= perf_passes_d;
         perf_reqs_q   <= perf_reqs_d;
         perf_stall_q  <= perf_stall_d;
      end
   end

   assign perf_passes_o = perf_passes_q;
   assign perf_reqs_o   = perf_reqs_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_sldu_p2_slide_seq.sv
// ----------------------------------------------------------------------------
// tb_sldu_p2_slide_seq
// Scoreboard bench for the power-of-two slide sequencer (NrLanes = 4,
// StrideW = 5). Expected passes/responses are queued when a request is
// driven; a negedge monitor pops and compares on every handshake.
// ----------------------------------------------------------------------------
module tb_sldu_p2_slide_seq;

   logic clk_i   = 1'b0;
   logic rst_ni  = 1'b0;
   logic flush_i = 1'b0;
   logic busy_o;
`ifdef SLDU_P2_SEQ_PERF_EN
   logic [31:0] perf_passes_o, perf_reqs_o, perf_stall_o;
`endif

   sldu_p2_slide_seq_if #(.StrideW(5), .IdWidth(3), .NpW(4)) sbus ();

   sldu_p2_slide_seq #(.NrLanes(4), .IdWidth(3)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .bus     (sbus),
      .busy_o  (busy_o)
`ifdef SLDU_P2_SEQ_PERF_EN
      ,
      .perf_passes_o (perf_passes_o),
      .perf_reqs_o   (perf_reqs_o),
      .perf_stall_o  (perf_stall_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [4:0] stride;
      logic       dir;
      logic       last;
   } exp_pass_t;

   typedef struct {
      logic [2:0] id;
      logic [3:0] np;
   } exp_rsp_t;

   exp_pass_t pass_sb[$];
   exp_rsp_t  rsp_sb[$];
   exp_pass_t ep;
   exp_rsp_t  er;
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Reference model: passes in ascending bit order, last when nothing remains.
   task automatic push_req(input logic [4:0] s, input logic d, input logic [2:0] id,
                           input int max_p, input bit want_rsp);
      logic [4:0] rem;
      int np;
      exp_pass_t p;
      exp_rsp_t  r;
      rem = s;
      np  = 0;
      for (int i = 0; i < 5; i++) begin
         if (s[i]) begin
            rem[i] = 1'b0;
            np++;
            if (np <= max_p) begin
               p.stride    = 5'd0;
               p.stride[i] = 1'b1;
               p.dir       = d;
               p.last      = (rem == 5'd0);
               pass_sb.push_back(p);
            end
         end
      end
      if (want_rsp) begin
         r.id = id;
         r.np = np[3:0];
         rsp_sb.push_back(r);
      end
   endtask

   task automatic send_req(input logic [4:0] s, input logic d, input logic [2:0] id);
      int n;
      n = 0;
      sbus.req_valid_i  = 1'b1;
      sbus.req_stride_i = s;
      sbus.req_dir_i    = d;
      sbus.req_id_i     = id;
      while (!sbus.req_ready_o && n < 50) begin
         step();
         n++;
      end
      if (n == 50) chk("req_ready_wait", {31'd0, sbus.req_ready_o}, 32'd1);
      step();
      sbus.req_valid_i = 1'b0;
   endtask

   task automatic wait_pass();
      int n;
      n = 0;
      while (!sbus.pass_valid_o && n < 50) begin
         step();
         n++;
      end
      chk("pass_valid_wait", {31'd0, sbus.pass_valid_o}, 32'd1);
   endtask

   task automatic run_passes(input int np, input int rdy_dly, input int done_dly);
      logic [4:0] s0;
      logic       l0;
      for (int k = 0; k < np; k++) begin
         wait_pass();
         s0 = sbus.pass_stride_o;
         l0 = sbus.pass_last_o;
         for (int c = 0; c < rdy_dly; c++) begin
            step();
            chk("pass_hold_valid", {31'd0, sbus.pass_valid_o}, 32'd1);
            chk("pass_hold_stride", {27'd0, sbus.pass_stride_o}, {27'd0, s0});
            chk("pass_hold_last", {31'd0, sbus.pass_last_o}, {31'd0, l0});
         end
         sbus.pass_ready_i = 1'b1;
         step();
         sbus.pass_ready_i = 1'b0;
         repeat (done_dly) step();
         sbus.pass_done_i = 1'b1;
         step();
         sbus.pass_done_i = 1'b0;
      end
   endtask

   task automatic take_rsp();
      int n;
      n = 0;
      while (!sbus.rsp_valid_o && n < 50) begin
         step();
         n++;
      end
      chk("rsp_valid_wait", {31'd0, sbus.rsp_valid_o}, 32'd1);
      sbus.rsp_ready_i = 1'b1;
      step();
      sbus.rsp_ready_i = 1'b0;
   endtask

   // Handshake monitor, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (sbus.pass_valid_o && sbus.pass_ready_i) begin
            if (pass_sb.size() == 0) begin
               chk("pass_unexpected", pass_sb.size(), 32'd1);
            end else begin
               ep = pass_sb.pop_front();
               chk("pass_stride", {27'd0, sbus.pass_stride_o}, {27'd0, ep.stride});
               chk("pass_dir", {31'd0, sbus.pass_dir_o}, {31'd0, ep.dir});
               chk("pass_last", {31'd0, sbus.pass_last_o}, {31'd0, ep.last});
            end
         end
         if (sbus.rsp_valid_o && sbus.rsp_ready_i) begin
            if (rsp_sb.size() == 0) begin
               chk("rsp_unexpected", rsp_sb.size(), 32'd1);
            end else begin
               er = rsp_sb.pop_front();
               chk("rsp_id", {29'd0, sbus.rsp_id_o}, {29'd0, er.id});
               chk("rsp_npasses", {28'd0, sbus.rsp_npasses_o}, {28'd0, er.np});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sbus.req_valid_i  = 1'b0;
      sbus.req_stride_i = 5'd0;
      sbus.req_dir_i    = 1'b0;
      sbus.req_id_i     = 3'd0;
      sbus.pass_ready_i = 1'b0;
      sbus.pass_done_i  = 1'b0;
      sbus.rsp_ready_i  = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      step();

      // Reset state
      chk("rst_req_ready", {31'd0, sbus.req_ready_o}, 32'd1);
      chk("rst_pass_valid", {31'd0, sbus.pass_valid_o}, 32'd0);
      chk("rst_pass_stride", {27'd0, sbus.pass_stride_o}, 32'd0);
      chk("rst_rsp_valid", {31'd0, sbus.rsp_valid_o}, 32'd0);
      chk("rst_rsp_np", {28'd0, sbus.rsp_npasses_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);

      // 1: stride 13 up -> 1, 4, 8
      push_req(5'd13, 1'b0, 3'd5, 5, 1'b1);
      send_req(5'd13, 1'b0, 3'd5);
      chk("t1_first_pass_lat", {31'd0, sbus.pass_valid_o}, 32'd1);
      chk("t1_busy", {31'd0, busy_o}, 32'd1);
      run_passes(3, 0, 1);
      chk("t1_rsp_lat", {31'd0, sbus.rsp_valid_o}, 32'd1);
      take_rsp();
      chk("t1_ready_after_rsp", {31'd0, sbus.req_ready_o}, 32'd1);

      // 2: stride 0 -> response only
      push_req(5'd0, 1'b1, 3'd2, 5, 1'b1);
      send_req(5'd0, 1'b1, 3'd2);
      chk("t2_rsp_lat", {31'd0, sbus.rsp_valid_o}, 32'd1);
      chk("t2_no_pass", {31'd0, sbus.pass_valid_o}, 32'd0);
      take_rsp();

      // 3: stride 16 down, ready held low 5 cycles
      push_req(5'd16, 1'b1, 3'd3, 5, 1'b1);
      send_req(5'd16, 1'b1, 3'd3);
      chk("t3_stride", {27'd0, sbus.pass_stride_o}, 32'd16);
      chk("t3_last", {31'd0, sbus.pass_last_o}, 32'd1);
      run_passes(1, 5, 2);
      take_rsp();

      // 4: stride 31, flush in WAIT after the 2nd pass
      push_req(5'd31, 1'b0, 3'd4, 2, 1'b0);
      send_req(5'd31, 1'b0, 3'd4);
      run_passes(1, 0, 0);
      wait_pass();
      sbus.pass_ready_i = 1'b1;
      step();
      sbus.pass_ready_i = 1'b0;
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("t4_busy", {31'd0, busy_o}, 32'd0);
      chk("t4_pass_valid", {31'd0, sbus.pass_valid_o}, 32'd0);
      chk("t4_pass_stride", {27'd0, sbus.pass_stride_o}, 32'd0);
      chk("t4_rsp_valid", {31'd0, sbus.rsp_valid_o}, 32'd0);
      chk("t4_req_ready", {31'd0, sbus.req_ready_o}, 32'd1);
      sbus.rsp_ready_i = 1'b1;
      repeat (3) step();
      sbus.rsp_ready_i = 1'b0;
      push_req(5'd6, 1'b1, 3'd7, 5, 1'b1);
      send_req(5'd6, 1'b1, 3'd7);
      run_passes(2, 0, 2);
      take_rsp();

      // 5: response back-pressure blocks a new request
      push_req(5'd3, 1'b0, 3'd1, 5, 1'b1);
      send_req(5'd3, 1'b0, 3'd1);
      run_passes(2, 0, 0);
      chk("t5_rsp_valid", {31'd0, sbus.rsp_valid_o}, 32'd1);
      push_req(5'd2, 1'b1, 3'd6, 5, 1'b1);
      sbus.req_valid_i  = 1'b1;
      sbus.req_stride_i = 5'd2;
      sbus.req_dir_i    = 1'b1;
      sbus.req_id_i     = 3'd6;
      for (int c = 0; c < 4; c++) begin
         chk("t5_req_ready_low", {31'd0, sbus.req_ready_o}, 32'd0);
         chk("t5_rsp_held", {31'd0, sbus.rsp_valid_o}, 32'd1);
         chk("t5_rsp_id_held", {29'd0, sbus.rsp_id_o}, 32'd1);
         chk("t5_no_pass", {31'd0, sbus.pass_valid_o}, 32'd0);
         step();
      end
      sbus.rsp_ready_i = 1'b1;
      step();
      sbus.rsp_ready_i = 1'b0;
      chk("t5_req_ready_back", {31'd0, sbus.req_ready_o}, 32'd1);
      step();
      sbus.req_valid_i = 1'b0;
      run_passes(1, 0, 0);
      take_rsp();

      // 6: done pulses in ISSUE and in the handshake cycle are ignored
      push_req(5'd5, 1'b0, 3'd2, 5, 1'b1);
      send_req(5'd5, 1'b0, 3'd2);
      wait_pass();
      sbus.pass_done_i = 1'b1;
      step();
      chk("t6_still_issue", {31'd0, sbus.pass_valid_o}, 32'd1);
      chk("t6_stride_kept", {27'd0, sbus.pass_stride_o}, 32'd1);
      sbus.pass_ready_i = 1'b1;
      step();
      sbus.pass_ready_i = 1'b0;
      sbus.pass_done_i  = 1'b0;
      repeat (2) begin
         step();
         chk("t6_wait_hold", {31'd0, sbus.pass_valid_o}, 32'd0);
         chk("t6_wait_busy", {31'd0, busy_o}, 32'd1);
      end
      sbus.pass_done_i = 1'b1;
      step();
      sbus.pass_done_i = 1'b0;
      run_passes(1, 0, 0);
      take_rsp();

      // 7: request together with flush is discarded
      sbus.req_valid_i  = 1'b1;
      sbus.req_stride_i = 5'd9;
      flush_i = 1'b1;
      step();
      sbus.req_valid_i = 1'b0;
      flush_i = 1'b0;
      chk("t7_busy", {31'd0, busy_o}, 32'd0);
      chk("t7_pass_valid", {31'd0, sbus.pass_valid_o}, 32'd0);
      step();
      chk("t7_rsp_valid", {31'd0, sbus.rsp_valid_o}, 32'd0);

      // 8: async reset mid-operation
      send_req(5'd31, 1'b0, 3'd0);
      chk("t8_issue", {31'd0, sbus.pass_valid_o}, 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("t8_rst_pass_valid", {31'd0, sbus.pass_valid_o}, 32'd0);
      chk("t8_rst_req_ready", {31'd0, sbus.req_ready_o}, 32'd1);
      chk("t8_rst_busy", {31'd0, busy_o}, 32'd0);
      step();
      rst_ni = 1'b1;
      step();

      chk("sb_pass_empty", pass_sb.size(), 32'd0);
      chk("sb_rsp_empty", rsp_sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
